// File: rtl/trng_pkg.sv
// Shared constants, debias state encoding and width helper for the trng_gen slice.
package trng_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int CHANNELS_DEF  = 4;
    localparam int DEPTH_DEF     = 4;
    localparam int REP_LIMIT_DEF = 32;

    typedef enum logic {
        PAIR_A = 1'b0,
        PAIR_B = 1'b1
    } debias_e;

    // Smallest n with 2**n >= v; used for pointer and counter widths.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/trng_gen_if.sv
// Valid/ready output channel carrying random words from trng_gen to a consumer.
interface trng_gen_if #(
    parameter int WIDTH = trng_pkg::WIDTH_DEF
);
    logic [WIDTH-1:0] rand_out;
    logic             rand_valid;
    logic             rand_ready;

    modport master (output rand_out, output rand_valid, input rand_ready);
    modport slave  (input rand_out, input rand_valid, output rand_ready);
endinterface

// File: rtl/trng_fifo.sv
// First-word-fall-through FIFO with flush; the head output holds its last value when empty.
module trng_fifo
    import trng_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = clog2(DEPTH);

    logic [AW:0]                  wptr, rptr;
    logic [DEPTH-1:0][WIDTH-1:0]  mem;
    logic [WIDTH-1:0]             last;
    logic                         do_push, do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? last : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
            mem  <= '0;
            last <= '0;
        end else begin
            // Remember the head so the output stays stable once the FIFO drains.
            if (!empty) last <= mem[rptr[AW-1:0]];
            if (flush) begin
                rptr <= wptr;
            end else begin
                if (do_push) begin
                    mem[wptr[AW-1:0]] <= din;
                    wptr              <= wptr + 1'b1;
                end
                if (do_pop) rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/trng_gen.sv
// Ring-oscillator TRNG: sync + XOR combine, repetition health test, von Neumann debias, word assembly, FIFO.
module trng_gen
    import trng_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int CHANNELS  = CHANNELS_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int REP_LIMIT = REP_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [CHANNELS-1:0] entropy_in,
    trng_gen_if.master          rnd,
    output logic                health_fail,
    input  logic                health_clr
);
    localparam int CW = clog2(REP_LIMIT + 1);
    localparam int BW = clog2(WIDTH);

    logic [CHANNELS-1:0] sync1, sync2;
    logic                raw, raw_prev;
    logic [CW-1:0]       rep_cnt, rep_nxt;
    logic                limit_hit;

    debias_e             state;
    logic                first;
    logic [WIDTH-1:0]    shreg, word;
    logic [BW-1:0]       bit_cnt;
    logic                harvest, emit, word_done;
    logic                fifo_push, fifo_pop, fifo_empty, fifo_full;

    // Per-channel two-flop synchronisers run independently of en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= entropy_in;
            sync2 <= sync1;
        end
    end

    assign raw = ^sync2;

    always_comb begin
        rep_nxt = rep_cnt;
        if (en) begin
            if (raw == raw_prev)
                rep_nxt = (rep_cnt == CW'(REP_LIMIT)) ? rep_cnt : rep_cnt + 1'b1;
            else
                rep_nxt = CW'(1);
        end
        // A simultaneous clear beats the alarm.
        limit_hit = en && (rep_nxt == CW'(REP_LIMIT)) && !health_clr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_prev    <= 1'b0;
            rep_cnt     <= '0;
            health_fail <= 1'b0;
        end else begin
            if (en) raw_prev <= raw;
            if (health_clr) begin
                rep_cnt     <= '0;
                health_fail <= 1'b0;
            end else begin
                rep_cnt <= rep_nxt;
                if (limit_hit) health_fail <= 1'b1;
            end
        end
    end

    assign harvest   = en && !health_fail && !limit_hit;
    assign emit      = harvest && (state == PAIR_B) && (first != raw);
    assign word      = {shreg[WIDTH-2:0], first};
    assign word_done = emit && (bit_cnt == BW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= PAIR_A;
            first   <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (limit_hit) begin
            state   <= PAIR_A;
            first   <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (!en) begin
            state <= PAIR_A;
        end else if (harvest) begin
            if (state == PAIR_A) begin
                first <= raw;
                state <= PAIR_B;
            end else begin
                state <= PAIR_A;
            end
            if (emit) begin
                shreg   <= word;
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    // A completed word is dropped only when the FIFO is full and not draining this edge.
    assign fifo_pop   = rnd.rand_valid && rnd.rand_ready;
    assign fifo_push  = word_done && (!fifo_full || fifo_pop);
    assign rnd.rand_valid = !fifo_empty;

    trng_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (limit_hit),
        .din     (word),
        .dout    (rnd.rand_out),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_trng_gen.sv
// Scoreboard bench for trng_gen: a reference model predicts FIFO contents, checked at every pop.
module tb_trng_gen;
    localparam int LIM = 32;
    localparam int FD  = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       health_clr = 1'b0;
    logic [3:0] entropy_in = '0;
    logic       health_fail;

    trng_gen_if #(.WIDTH(8)) rif();

    trng_gen #(
        .WIDTH(8), .CHANNELS(4), .DEPTH(4), .REP_LIMIT(32)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .entropy_in  (entropy_in),
        .rnd         (rif),
        .health_fail (health_fail),
        .health_clr  (health_clr)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    bit         noisy = 1'b1;
    logic [7:0] q[$];
    logic [7:0] popped[$];
    bit         bq[$];

    logic [3:0] m_s1, m_s2;
    bit         m_prev, m_fail, m_st, m_first;
    int         m_cnt, m_nb;
    logic [7:0] m_sh, m_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] mk_ent(input bit b);
        logic [2:0] x;
        x = noisy ? 3'($urandom) : 3'b011;
        return {x, b ^ (^x)};
    endfunction

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_prev = 0; m_fail = 0; m_st = 0; m_first = 0;
        m_cnt = 0; m_nb = 0; m_sh = '0; m_last = '0;
        q.delete();
    endtask

    // Called at a falling edge: check outputs, drive inputs, advance model, step one clock.
    task automatic cyc(input bit e, input logic [3:0] ent, input bit clr, input bit rdy);
        bit r, hit, pop, push;
        int cn;
        logic [7:0] w;
        chk("valid", rif.rand_valid, q.size() != 0);
        chk("fail", health_fail, m_fail);
        if (q.size() != 0) begin
            chk(rdy ? "pop" : "head", rif.rand_out, q[0]);
            m_last = q[0];
        end else begin
            chk("hold", rif.rand_out, m_last);
        end
        pop = rdy && (q.size() != 0);
        if (pop) popped.push_back(rif.rand_out);
        en = e; entropy_in = ent; health_clr = clr; rif.rand_ready = rdy;

        r = ^m_s2; cn = m_cnt; hit = 0; push = 0; w = '0;
        if (e) begin
            cn = (r == m_prev) ? ((m_cnt < LIM) ? m_cnt + 1 : LIM) : 1;
            m_prev = r;
            hit = (cn == LIM) && !clr;
        end
        if (hit) begin
            m_st = 0; m_sh = '0; m_nb = 0;
        end else if (!e) begin
            m_st = 0;
        end else if (!m_fail) begin
            if (!m_st) begin
                m_first = r; m_st = 1;
            end else begin
                m_st = 0;
                if (m_first != r) begin
                    w = {m_sh[6:0], m_first};
                    m_sh = w;
                    if (m_nb == 7) begin push = 1; m_nb = 0; end
                    else m_nb++;
                end
            end
        end
        if (clr) begin m_fail = 0; m_cnt = 0; end
        else begin m_cnt = cn; if (hit) m_fail = 1; end
        if (hit) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push && q.size() < FD) q.push_back(w);
        end
        m_s2 = m_s1; m_s1 = ent;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, mk_ent(1'b0), 1'b0, rdy);
    endtask

    // Two en-low cycles prime the synchronisers, then one en-high edge per queued raw bit.
    task automatic feed(input bit rdy, input int clr_at);
        int n;
        n = bq.size();
        for (int j = 0; j < n + 2; j++)
            cyc(j >= 2, mk_ent((j < n) ? bq[j] : bq[n-1]), (clr_at >= 0) && (j == clr_at + 2), rdy);
        bq.delete();
    endtask

    // Raw bit pairs that debias to w (MSB first); optional 11/00 filler pairs in between.
    task automatic add_word(input logic [7:0] w, input bit fill);
        for (int i = 7; i >= 0; i--) begin
            bq.push_back(w[i]);
            bq.push_back(!w[i]);
            if (fill && (i % 2 == 1)) begin
                bq.push_back(i[1]);
                bq.push_back(i[1]);
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; en = 1'b0; health_clr = 1'b0; rif.rand_ready = 1'b0;
        #1;
        chk("rst_out", rif.rand_out, 8'h00);
        chk("rst_valid", rif.rand_valid, 1'b0);
        chk("rst_fail", health_fail, 1'b0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [7:0] bw[5];
    int p0;

    initial begin
        rif.rand_ready = 1'b0;
        bw[0] = 8'h3C; bw[1] = 8'hA5; bw[2] = 8'h0F; bw[3] = 8'h96; bw[4] = 8'h5A;
        model_clear();
        @(negedge clk);
        do_reset();

        // Alternating raw bits: first word 0xFF, valid from the 16th en edge
        for (int j = 0; j < 20; j++) begin
            cyc(j >= 2, mk_ent(j % 2 == 0), 1'b0, 1'b1);
            if (j == 16) chk("alt_v15", rif.rand_valid, 1'b0);
            if (j == 17) begin
                chk("alt_v16", rif.rand_valid, 1'b1);
                chk("alt_word", rif.rand_out, 8'hFF);
            end
        end

        // Pattern 10,11,01,00 repeated -> 0xAA words
        do_reset();
        p0 = popped.size();
        for (int k = 0; k < 8; k++) begin
            bq.push_back(1); bq.push_back(0); bq.push_back(1); bq.push_back(1);
            bq.push_back(0); bq.push_back(1); bq.push_back(0); bq.push_back(0);
        end
        feed(1'b1, -1);
        idle(3, 1'b1);
        chk("pat_n", popped.size() - p0, 2);
        chk("pat_w0", popped[p0], 8'hAA);
        chk("pat_w1", popped[p0+1], 8'hAA);

        // Constant input: alarm on 32nd equal sample, flush, then clear and resume
        do_reset();
        add_word(8'hA5, 1'b0);
        feed(1'b0, -1);
        chk("const_pre_valid", rif.rand_valid, 1'b1);
        noisy = 1'b0;
        for (int k = 0; k < 31; k++) bq.push_back(1);
        feed(1'b0, -1);
        chk("const_31_fail", health_fail, 1'b0);
        chk("const_31_valid", rif.rand_valid, 1'b1);
        bq.push_back(1);
        feed(1'b0, -1);
        chk("const_32_fail", health_fail, 1'b1);
        chk("const_32_flush", rif.rand_valid, 1'b0);
        idle(3, 1'b1);
        chk("const_sticky", health_fail, 1'b1);
        cyc(1'b0, mk_ent(1'b1), 1'b1, 1'b1);
        chk("const_clr", health_fail, 1'b0);
        noisy = 1'b1;
        p0 = popped.size();
        add_word(8'h3C, 1'b0);
        feed(1'b1, -1);
        idle(3, 1'b1);
        chk("resume_n", popped.size() - p0, 1);
        chk("resume_w", popped[p0], 8'h3C);

        // Backpressure: 5 words with ready low, 4 kept in order, 5th dropped
        do_reset();
        for (int k = 0; k < 5; k++) add_word(bw[k], 1'b1);
        feed(1'b0, -1);
        chk("bp_valid", rif.rand_valid, 1'b1);
        p0 = popped.size();
        idle(8, 1'b1);
        chk("bp_n", popped.size() - p0, 4);
        for (int k = 0; k < 4; k++) chk("bp_word", popped[p0+k], bw[k]);
        chk("bp_empty", rif.rand_valid, 1'b0);

        // Reset mid-word after 5 emitted bits
        do_reset();
        add_word(8'hC3, 1'b0);
        feed(1'b0, -1);
        for (int k = 0; k < 5; k++) begin bq.push_back(1); bq.push_back(0); end
        feed(1'b0, -1);
        chk("mid_pre_out", rif.rand_out, 8'hC3);
        do_reset();
        p0 = popped.size();
        add_word(8'h81, 1'b0);
        feed(1'b1, -1);
        idle(3, 1'b1);
        chk("mid_n", popped.size() - p0, 1);
        chk("mid_word", popped[p0], 8'h81);

        // Clear coinciding with the 32nd equal sample wins; counter restarts at 0
        do_reset();
        noisy = 1'b0;
        for (int k = 0; k < 32; k++) bq.push_back(1);
        feed(1'b1, 31);
        chk("coll_fail", health_fail, 1'b0);
        for (int k = 0; k < 31; k++) bq.push_back(1);
        feed(1'b1, -1);
        chk("coll_31", health_fail, 1'b0);
        bq.push_back(1);
        feed(1'b1, -1);
        chk("coll_32", health_fail, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trng_gen.md
# trng_gen

Parametrised true-random-number generator and the successor to the 8-bit `trng` core. It samples `CHANNELS` free-running ring-oscillator entropy inputs and synchronises and XOR-combines them. The combined stream passes through a von Neumann debiaser and a repetition-count health test, is assembled into `WIDTH`-bit words, and is buffered in a `DEPTH`-entry FIFO behind a valid/ready interface. It sits between the ring-oscillator macro and any consumer of random words, such as key or nonce logic.

## Interface
Parameters:
- `WIDTH`, 8: output word width in bits (≥2).
- `CHANNELS`, 4: number of entropy inputs (≥1).
- `DEPTH`, 4: FIFO entries; must be a power of 2 and ≥2.
- `REP_LIMIT`, 32: consecutive identical raw bits that trip the health alarm (≥2).

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset_n`, in, 1: asynchronous active-low reset.
- `en`, in, 1: enables bit harvesting.
- `entropy_in`, in, CHANNELS: asynchronous ring-oscillator taps.
- `rand_out`, out, WIDTH: FIFO head word.
- `rand_valid`, out, 1: the FIFO is non-empty.
- `rand_ready`, in, 1: consumer accepts `rand_out`.
- `health_fail`, out, 1: sticky health alarm.
- `health_clr`, in, 1: one-cycle pulse that clears the alarm and the repetition counter.

## Operation
- **Reset:** while `reset_n` = 0, the following are cleared:
  - `rand_out` = 0, `rand_valid` = 0, `health_fail` = 0;
  - synchronisers, debias state, shift register, bit count, repetition counter, and FIFO pointers and storage.
- **Sync:** each `entropy_in` bit passes through its own 2-flop synchroniser, which runs regardless of `en`. The raw bit `r` is the XOR of all stage-2 outputs.
- **Health test:** on every `en`-high edge, `r` is compared with the previous `r`.
  - Equal: the counter increments and saturates at `REP_LIMIT`. Different: the counter loads 1.
  - The counter reaching `REP_LIMIT` sets `health_fail`. On the same edge, the FIFO is flushed (made empty) and the partial word and debias state are discarded.
  - While `health_fail` = 1, no bits are harvested.
  - `health_clr` clears `health_fail` and loads the counter with 0. If `health_clr` coincides with the limit being reached, `health_clr` wins.
- **Debias FSM:** two states, `PAIR_A` and `PAIR_B`, advancing only on `en`-high edges.
  - `PAIR_A`: store `r` as `first`, go to `PAIR_B`.
  - `PAIR_B`: if `first` ≠ `r`, emit the bit `first` (so 10 gives 1 and 01 gives 0); otherwise emit nothing. Return to `PAIR_A`.
  - `en` = 0 forces `PAIR_A`. The partial word and counters hold.
- **Assembly:**
  - Each emitted bit shifts into the LSB (`shreg <= {shreg[WIDTH-2:0], bit}`), so the first bit ends up as the MSB.
  - Bit count wraps 0…WIDTH-1.
  - When count = WIDTH-1 and a bit is emitted, the word `{shreg[WIDTH-2:0], bit}` is written to the FIFO on that edge and the count returns to 0.
- **FIFO:** first-word-fall-through; `rand_out` is the head entry and `rand_valid` = !empty.
  - Pop on `rand_valid && rand_ready`.
  - Push while full with a pop on the same edge: both succeed. Push while full without a pop: the word is dropped and the FIFO is unchanged.
  - Push to an empty FIFO: visible the next cycle.
  - A flush on health fail overrides a simultaneous push or pop.
  - `rand_out` holds the last head value when empty. It is 0 after reset.

## Timing
- `entropy_in` change to `r`: 2 cycles.
- Best case (ideal alternating `r`, `en` high from edge 1): the word is written at edge 2·WIDTH; `rand_valid` is high from that edge onward.
- Output is registered, and `rand_valid` drops on the edge that pops the last entry.
- `health_fail` rises on the edge on which the counter reaches `REP_LIMIT`, i.e. the `REP_LIMIT`-th consecutive equal sample. It falls on the edge sampling `health_clr`.
- `reset_n` assertion mid-word or mid-handshake takes effect immediately with no edge needed. After release, harvesting restarts from `PAIR_A` with an empty FIFO.

## Structure
- **Package `trng_pkg`:** default parameter constants, the debias state enum (`PAIR_A`/`PAIR_B`), and a `clog2` helper for pointer and counter widths.
- **Sub-module `trng_fifo`:** parameters `WIDTH` and `DEPTH`.
  - Ports: push, pop, flush, data in/out, empty, full.
  - Asynchronous active-low reset. Pointers are one bit wider than the address for the full/empty distinction.
- **Top level:** synchronisers, health test, debias FSM and assembler.

## Test plan
All scenarios use default parameters.
- **Alternating bits:** drive `entropy_in` so that `r` alternates 1,0,1,0…, `en`=1, `rand_ready`=1 → first word 0xFF, `rand_valid` high from edge 16 of `en`.
- **Pattern word:** pairs 10,01 repeated → word 0xAA. Pairs 11/00 interleaved between them produce no bits and do not change the word.
- **Constant input:** `entropy_in` constant → no words. `health_fail` rises on the 32nd equal sample and the FIFO empties. A `health_clr` pulse drops the alarm and harvesting resumes.
- **Backpressure:** `rand_ready`=0 while 5 words are generated → 4 words buffered and the 5th dropped. Raising `rand_ready` yields exactly 4 pops in order, after which `rand_valid`=0.
- **Reset mid-word:** pulse `reset_n` low after 5 emitted bits → all outputs 0 immediately. The next word contains only bits emitted after release.
- **Clear vs. alarm collision:** `health_clr` on the same edge as the 32nd equal sample → `health_fail` stays 0 and the counter reads 0.
